// File: rtl/storage_arb_pkg.sv
// Shared types and helpers for the storage access arbiter.
// Holds the FSM state enum and the round-robin pick function.
package storage_arb_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;
    localparam int MAX_REQ    = 8;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RESP
    } state_t;

    // First set bit above 'last', wrapping within n requesters.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [2:0]         last,
        input int                 n
    );
        logic [MAX_REQ-1:0] pick;
        logic               found;
        logic [2:0]         idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 1; k <= MAX_REQ; k++) begin
            idx = 3'((int'(last) + k) % n);
            if (k <= n && !found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/storage_access_arbiter_bank.sv
// Register-based storage bank with one write port and a
// registered, enable-held read port; clears on reset.
module storage_bank
    import storage_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Word array: indexed write, whole bank zeroed on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: only moves on a read, so data holds between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/storage_access_arbiter.sv
// Round-robin arbiter sharing one storage bank among requesters.
// IDLE picks a winner, GRANT performs the access, RESP returns read data.
module storage_access_arbiter
    import storage_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy
);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  owner_q, owner_d;
    logic [2:0]          last_q, last_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [MAX_REQ-1:0]  pick;
    logic [2:0]          win;

    assign pick = rr_pick(MAX_REQ'(req), last_q, NUM_REQ);

    // One-hot winner to index, remembered as the new rotation point.
    always_comb begin
        win = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick[i]) win = 3'(i);
        end
    end

    // Next state; the winner's command is captured on leaving IDLE.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = GRANT;
                    last_d  = win;
                    owner_d = pick[NUM_REQ-1:0];
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (pick[i]) begin
                            cmd_we_d    = req_we[i];
                            cmd_addr_d  = req_addr[i*ADDR_W +: ADDR_W];
                            cmd_wdata_d = req_wdata[i*DATA_W +: DATA_W];
                        end
                    end
                end
            end
            GRANT:   state_d = cmd_we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and command registers; reset points rotation at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            last_q      <= 3'(NUM_REQ - 1);
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
        end
    end

    assign gnt    = (state_q == GRANT) ? owner_q : '0;
    assign rvalid = (state_q == RESP)  ? owner_q : '0;
    assign busy   = (state_q != IDLE);

    storage_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (state_q == GRANT && cmd_we_q),
        .waddr (cmd_addr_q),
        .wdata (cmd_wdata_q),
        .re    (state_q == GRANT && !cmd_we_q),
        .raddr (cmd_addr_q),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_storage_access_arbiter.sv
// Bench for storage_access_arbiter: transaction-level model with
// per-cycle output comparison, directed scenarios and random traffic.
module tb_storage_access_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    gnt;
    logic [N-1:0]    rvalid;
    logic [DW-1:0]   rdata;
    logic            busy;

    storage_access_arbiter #(
        .NUM_REQ (N),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int got[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference model: transactions scheduled by cycle number.
    logic [DW-1:0] m_mem [2**AW];
    int            m_last;
    int            free_at;
    logic [N-1:0]  exp_gnt  [int];
    logic [N-1:0]  exp_rv   [int];
    logic [DW-1:0] exp_rd   [int];
    bit            exp_busy [int];
    logic [DW-1:0] cur_rd;

    always @(posedge clk) begin
        int n, w, idx;
        logic [AW-1:0] a;
        n   = cyc;
        cyc = cyc + 1;
        if (!rst_n) begin
            for (int i = 0; i < 2**AW; i++) m_mem[i] = '0;
            m_last  = N - 1;
            free_at = n + 1;
            exp_gnt.delete();
            exp_rv.delete();
            exp_rd.delete();
            exp_busy.delete();
        end else if (n >= free_at && req != '0) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                idx = (m_last + k) % N;
                if (w < 0 && req[idx]) w = idx;
            end
            m_last = w;
            exp_gnt[n+1]  = N'(1) << w;
            exp_busy[n+1] = 1'b1;
            a = req_addr[w*AW +: AW];
            if (req_we[w]) begin
                m_mem[a] = req_wdata[w*DW +: DW];
                free_at  = n + 2;
            end else begin
                exp_rv[n+2]   = N'(1) << w;
                exp_rd[n+2]   = m_mem[a];
                exp_busy[n+2] = 1'b1;
                free_at       = n + 3;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [N-1:0] eg, ev;
        bit eb;
        int c;
        c = cyc;
        if (!rst_n) begin
            eg     = '0;
            ev     = '0;
            eb     = 1'b0;
            cur_rd = '0;
        end else begin
            eg = exp_gnt.exists(c) ? exp_gnt[c] : '0;
            ev = exp_rv.exists(c)  ? exp_rv[c]  : '0;
            eb = exp_busy.exists(c);
            if (exp_rd.exists(c)) cur_rd = exp_rd[c];
        end
        check("gnt", 32'(gnt), 32'(eg));
        check("rvalid", 32'(rvalid), 32'(ev));
        check("busy", 32'(busy), 32'(eb));
        check("rdata", 32'(rdata), 32'(cur_rd));
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input bit we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]               = 1'b1;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic collect(input int n, input bit drop);
        int idx;
        got.delete();
        for (int t = 0; t < 40; t++) begin
            step();
            if (gnt != '0) begin
                idx = $clog2(gnt);
                got.push_back(idx);
                if (drop) req[idx] = 1'b0;
                if (got.size() == n) return;
            end
        end
        check("collect_timeout", 32'(got.size()), 32'(n));
    endtask

    task automatic idle(input int n);
        for (int t = 0; t < n; t++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        idle(3);
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_rr[5];
        int bound;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        rst_n     = 1'b0;
        idle(3);
        rst_n = 1'b1;

        idle(10);
        check("idle_gnt", 32'(gnt), 32'h0);
        check("idle_rvalid", 32'(rvalid), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_rdata", 32'(rdata), 32'h0);

        set_cmd(0, 1'b1, 2'd2, 8'hA5);
        step();
        check("wr_gnt", 32'(gnt), 32'b0001);
        check("wr_busy", 32'(busy), 32'h1);
        set_cmd(0, 1'b0, 2'd2, 8'h00);
        step();
        check("wr_done_busy", 32'(busy), 32'h0);
        step();
        check("rd_gnt", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        step();
        check("rd_rvalid", 32'(rvalid), 32'b0001);
        check("rd_rdata", 32'(rdata), 32'hA5);
        idle(2);

        do_reset();
        idle(2);
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 2'd0, 8'h00);
        collect(5, 1'b0);
        req = '0;
        exp_rr = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) check("rr_order", 32'(got[i]), 32'(exp_rr[i]));
        end
        idle(4);

        set_cmd(1, 1'b0, 2'd0, 8'h00);
        collect(1, 1'b1);
        idle(3);
        set_cmd(0, 1'b0, 2'd1, 8'h00);
        set_cmd(3, 1'b0, 2'd2, 8'h00);
        collect(2, 1'b1);
        if (got.size() == 2) begin
            check("pair_first", 32'(got[0]), 32'd3);
            check("pair_second", 32'(got[1]), 32'd0);
        end
        idle(4);

        set_cmd(0, 1'b1, 2'd1, 8'h5A);
        collect(1, 1'b1);
        idle(2);
        set_cmd(0, 1'b0, 2'd1, 8'h00);
        bound = 0;
        while (gnt[0] !== 1'b1 && bound < 10) begin
            step();
            bound++;
        end
        check("rst_rd_gnt", 32'(gnt), 32'b0001);
        rst_n = 1'b0;
        req   = '0;
        step();
        check("rst_rvalid", 32'(rvalid), 32'h0);
        step();
        check("rst_rdata", 32'(rdata), 32'h0);
        rst_n = 1'b1;
        idle(2);
        set_cmd(0, 1'b0, 2'd1, 8'h00);
        collect(1, 1'b1);
        step();
        check("post_rst_rvalid", 32'(rvalid), 32'b0001);
        check("post_rst_rdata", 32'(rdata), 32'h0);
        idle(3);

        set_cmd(1, 1'b1, 2'd3, 8'h3C);
        step();
        check("raw_wr_gnt", 32'(gnt), 32'b0010);
        set_cmd(1, 1'b0, 2'd3, 8'h00);
        set_cmd(2, 1'b1, 2'd0, 8'hFF);
        step();
        req[2] = 1'b0;
        check("raw_gap_gnt", 32'(gnt), 32'h0);
        step();
        check("raw_rd_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        step();
        check("raw_rvalid", 32'(rvalid), 32'b0010);
        check("raw_rdata", 32'(rdata), 32'h3C);
        idle(3);

        for (int t = 0; t < 3000; t++) begin
            for (int i = 0; i < N; i++) begin
                if (gnt[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                    else set_cmd(i, 1'($urandom_range(0, 1)),
                                 2'($urandom_range(0, 3)), 8'($urandom));
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0)
                        set_cmd(i, 1'($urandom_range(0, 1)),
                                2'($urandom_range(0, 3)), 8'($urandom));
                end else if ($urandom_range(0, 15) == 0) begin
                    req[i] = 1'b0;
                end
            end
            step();
        end
        req = '0;
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/storage_access_arbiter.md
Name: storage_access_arbiter

Overview:
Shares one small register-based storage bank between NUM_REQ requesters using round-robin arbitration. A three-state FSM sequences each granted access. Reads return data through a registered output stage. The arbiter sits between the client datapaths and the storage bank and is the only block that drives the bank's write enable.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, storage word width
ADDR_W, 2, storage address width; bank depth = 2**ADDR_W

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester access request, level, held until gnt seen
req_we  in  NUM_REQ  per-requester command: 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_W  packed per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed per-requester write data; slice [i*DATA_W +: DATA_W]
gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
rvalid  out  NUM_REQ  one-hot, one-cycle read-data-valid pulse
rdata  out  DATA_W  read data shared by all requesters; meaningful when any rvalid is high
busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE; gnt=0; rvalid=0; rdata=0; busy=0.
  - All bank words = 0.
  - last_winner = NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset asserted mid-transaction aborts it immediately. No partial write is permitted: a write commits only at the GRANT-cycle clock edge.
- FSM states: IDLE, GRANT, RESP.
- IDLE:
  - req is sampled every cycle.
  - If req != 0, winner w = first set bit searching from last_winner+1 upward, with wrap.
  - At the next edge: gnt[w]=1, last_winner=w, latch req_we/addr/wdata of w into cmd registers, state -> GRANT.
  - If req == 0: stay in IDLE; last_winner unchanged.
- GRANT (exactly 1 cycle, gnt[w] high):
  - Write: the bank word at cmd_addr takes cmd_wdata at the closing edge. State -> IDLE.
  - Read: rdata takes bank[cmd_addr] at the closing edge, and rvalid[w]=1 in the following cycle. State -> RESP.
- RESP (exactly 1 cycle, rvalid[w] high): state -> IDLE. rdata holds its value until the next read completes.
- Timing, counted from the cycle N in which the request is sampled in IDLE:
  - gnt in cycle N+1.
  - Write visible in the bank from cycle N+2.
  - Read data with rvalid in cycle N+2.
  - Next arbitration in cycle N+2 for a write, N+3 for a read.
- Requester rules:
  - Deassert req, or present the next command, in the cycle after seeing gnt.
  - Withdrawing req before a grant is legal; the arbiter evaluates req only in IDLE.
  - Command inputs are don't-care after the grant cycle because they were latched at grant.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.
- gnt and rvalid are always zero or one-hot; both are never high in the same cycle.
- Read-after-write to the same address in consecutive transactions returns the new data.
- A single lone requester is served back-to-back, with its grant every 2 cycles (write) or 3 cycles (read).

Decomposition:
- Package storage_arb_pkg holds:
  - the state enum (IDLE, GRANT, RESP);
  - localparam defaults for DATA_W and ADDR_W;
  - a function rr_pick(req, last) returning the one-hot winner.
- Sub-module storage_bank holds the register array, indexed write port (we, waddr, wdata), registered read port (raddr to rdata on clk) and asynchronous zero on reset.
- The arbiter/FSM stays in storage_access_arbiter.

Test Plan:
- Reset then idle: release rst_n with req=0 for 10 cycles -> gnt=0, rvalid=0, busy=0, rdata=0.
- Single write then read:
  - req0 writes addr 2 = 0xA5 -> gnt=0001 one cycle after request; busy high 1 cycle.
  - req0 then reads addr 2 -> gnt=0001, then rvalid=0001 with rdata=0xA5 in the next cycle.
- Round-robin: all four hold read requests to addr 0 continuously -> grant order 0,1,2,3,0; each rvalid matches the preceding gnt one cycle later.
- Simultaneous after partial rotation: last_winner=1, then req=1001 -> gnt=1000 first, then 0001.
- Reset mid-read: assert rst_n=0 during the GRANT of a read -> rvalid never pulses, rdata=0, and bank contents read back as 0 afterwards.
- Read-after-write and withdraw:
  - req1 writes addr 3 = 0x3C.
  - req2 pulses req for one cycle while the FSM is in GRANT, then drops it -> req2 is never granted.
  - req1 then reads addr 3 -> rdata=0x3C.
